cia_sp_bridge: RTL

- Byte-level bridge on the CIA serial port (SP/CNT pins), placed directly beside the CIA in the icestick 6502 system.
- Output direction: captures bytes the CIA shifts out on sp_out/cnt_out and presents them on a valid/ready byte stream through a small FIFO.
- Input direction: accepts bytes on a valid/ready stream and serialises them MSB-first onto the CIA's cnt_in/sp_in pins.
- Lets host-side logic (UART, SPI master, test harness) exchange bytes with 6502 software that uses the CIA SDR.

---
 rtl/cia_sp_pkg.sv | 12 +
 rtl/cia_sp_fifo.sv | 47 ++++
 rtl/cia_sp_bridge.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cia_sp_pkg.sv
// cia_sp_pkg: shared types, widths and helpers for the CIA serial-port bridge
package cia_sp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, WAIT} drv_state_t;

    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cia_sp_fifo.sv
// cia_sp_fifo: first-word-fall-through byte FIFO with full/empty flags
module cia_sp_fifo
    import cia_sp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = cw(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;
    logic              w_push;
    logic              w_pop;

    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    // read/write pointers; a push into a full FIFO is allowed only alongside a pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    // byte storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cia_sp_bridge.sv
// cia_sp_bridge: byte bridge on the CIA SP/CNT pins (capture FIFO + MSB-first driver);
// define CIA_SP_BRIDGE_TIMEOUT_EN to discard stale partial capture bytes after TIMEOUT phi2 ticks
module cia_sp_bridge
    import cia_sp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HALF    = 2,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phi2,
    input  logic              mode_out,
    input  logic              cnt_out_cia,
    input  logic              sp_out_cia,
    output logic              cnt_in_cia,
    output logic              sp_in_cia,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              overrun
);

    localparam int TW = cw(((HALF > GAP) ? HALF : GAP) + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HALF < 2 || GAP < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cia_sp_bridge: unsupported parameter set");
    end

    logic              r_cnt_prev;
    logic [2:0]        r_cap_cnt;
    logic [BYTE_W-2:0] r_cap_sh;
    logic [BYTE_W-1:0] w_cap_byte;
    logic              w_rise;
    logic              w_push;
    logic              w_cap_clr;
    logic              w_full;
    logic              w_empty;
    logic              r_overrun;

    assign w_rise     = phi2 & mode_out & cnt_out_cia & ~r_cnt_prev;
    assign w_cap_byte = {r_cap_sh, sp_out_cia};
    assign w_push     = w_rise & (r_cap_cnt == 3'd7);

`ifdef CIA_SP_BRIDGE_TIMEOUT_EN
    localparam int IW = cw(TIMEOUT + 1);

    logic [IW-1:0] r_idle;

    assign w_cap_clr = phi2 & ~w_rise & (r_cap_cnt != 3'd0) & (r_idle == IW'(TIMEOUT - 1));

    // phi2 ticks since the last CNT edge while a partial byte is pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_idle <= '0;
        else if (phi2) r_idle <= (w_rise | w_cap_clr | (r_cap_cnt == 3'd0)) ? '0 : r_idle + IW'(1);
    end
`else
    assign w_cap_clr = 1'b0;
`endif

    // capture shifter: first bit received ends up in the byte MSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_prev <= 1'b1;
            r_cap_cnt  <= '0;
            r_cap_sh   <= '0;
        end else if (phi2) begin
            r_cnt_prev <= cnt_out_cia;
            if (!mode_out || w_cap_clr) begin
                r_cap_cnt <= '0;
                r_cap_sh  <= '0;
            end else if (w_rise) begin
                r_cap_cnt <= r_cap_cnt + 3'd1;
                r_cap_sh  <= w_cap_byte[BYTE_W-2:0];
            end
        end
    end

    // flag a completed byte that the full FIFO could not take
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_overrun <= 1'b0;
        else r_overrun <= w_push & w_full & ~tx_ready;
    end

    assign overrun  = r_overrun;
    assign tx_valid = ~w_empty;

    cia_sp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_cap_byte),
        .i_pop   (tx_ready),
        .o_data  (tx_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    drv_state_t        r_state;
    drv_state_t        w_next;
    logic [TW-1:0]     r_tick;
    logic [2:0]        r_bit;
    logic [BYTE_W-1:0] r_drv_sh;
    logic              w_done;
    logic              w_load;

    assign rx_ready   = (r_state == IDLE) & ~mode_out;
    assign w_load     = rx_valid & rx_ready;
    assign w_done     = phi2 & (r_tick == ((r_state == WAIT) ? TW'(GAP - 1) : TW'(HALF - 1)));
    assign cnt_in_cia = r_state != LOW;
    assign sp_in_cia  = (r_state == LOW || r_state == HIGH) ? r_drv_sh[BYTE_W-1] : 1'b1;

    // drive FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // drive FSM next state; CIA taking over the line aborts any byte in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_load ? LOW : IDLE;
            LOW:     w_next = w_done ? HIGH : LOW;
            HIGH:    w_next = w_done ? ((r_bit == 3'd7) ? WAIT : LOW) : HIGH;
            WAIT:    w_next = w_done ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
        if (mode_out && r_state != IDLE) w_next = IDLE;
    end

    // drive shifter, bit index and phase tick counter; the shift lands as CNT falls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick   <= '0;
            r_bit    <= '0;
            r_drv_sh <= '0;
        end else begin
            if (w_load) begin
                r_drv_sh <= rx_data;
                r_bit    <= '0;
            end else if (r_state == HIGH && w_done && r_bit != 3'd7) begin
                r_drv_sh <= {r_drv_sh[BYTE_W-2:0], 1'b0};
                r_bit    <= r_bit + 3'd1;
            end
            r_tick <= (r_state == IDLE || mode_out || w_done) ? '0 : (phi2 ? r_tick + TW'(1) : r_tick);
        end
    end

endmodule
